// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the synchronous FIFO: default sizes, width helpers
// and the error code used by scoreboards.
package fifo_sync_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_DEPTH      = 8;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_OVF,
      ERR_UDF
   } err_e;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address 0..depth-1, never less than one.
   function automatic int unsigned ptr_w(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
// Contents are deliberately not reset.
module fifo_sync_mem
   import fifo_sync_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                       CLK,
   input  logic                       we,
   input  logic [ptr_w(DEPTH)-1:0]    waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [ptr_w(DEPTH)-1:0]    raddr,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] regs [DEPTH];

   // Write port; addresses are kept in range by the owning FIFO.
   always_ff @(posedge CLK) begin
      if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata = regs[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, flush and error pulses.
// Define FIFO_SYNC_FWFT_EN for first-word fall-through reads; otherwise the
// read path is a registered one-cycle stage.
module fifo_sync_param
   import fifo_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [cnt_w(DEPTH)-1:0]    count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_d;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // Accept decisions and next occupancy; a read frees a slot for a write when full.
   always_comb begin
      wr_acc  = wr_en & (~full | rd_en);
      rd_acc  = rd_en & ~empty;
      count_d = count;
      if (wr_acc & ~rd_acc) begin
         count_d = count + CW'(1);
      end else if (rd_acc & ~wr_acc) begin
         count_d = count - CW'(1);
      end
   end

   fifo_sync_mem #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .CLK   (CLK),
      .we    (wr_acc & ~clear & ~RST),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   // Pointers, occupancy and flags; flags follow the post-update count directly.
   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count        <= count_d;
         full         <= (count_d == CNT_FULL);
         empty        <= (count_d == '0);
         almost_full  <= (count_d >= CNT_AF);
         almost_empty <= (count_d <= CNT_AE);
         overflow     <= wr_en & full & ~rd_en;
         underflow    <= rd_en & empty;
      end
   end

`ifdef FIFO_SYNC_FWFT_EN
   // Head entry is always visible; rd_en only acknowledges it.
   assign rd_data  = mem_rdata;
   assign rd_valid = ~empty;
`else
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   // Registered read stage; flush keeps the last word but drops the valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else if (clear) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem_rdata;
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a DEPTH=8 and a DEPTH=5 instance checked every
// cycle against a queue-based reference model.
module tb_fifo_sync_param;
   import fifo_sync_pkg::*;

   logic       CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst [2];
   logic       clr [2];
   logic       we  [2];
   logic       re  [2];
   logic [7:0] wd  [2];
   logic [7:0] rdd [2];
   logic       rv  [2];
   logic       fu  [2];
   logic       em  [2];
   logic       af  [2];
   logic       ae  [2];
   logic       ov  [2];
   logic       un  [2];
   logic [3:0] cnt8;
   logic [2:0] cnt5;

   int unsigned dep  [2];
   int unsigned afth [2];
   int unsigned aeth [2];

   fifo_sync_param #(
      .DATA_WIDTH (8),
      .DEPTH      (8),
      .AF_THRESH  (6),
      .AE_THRESH  (2)
   ) dut8 (
      .CLK          (CLK),
      .RST          (rst[0]),
      .clear        (clr[0]),
      .wr_en        (we[0]),
      .wr_data      (wd[0]),
      .rd_en        (re[0]),
      .rd_data      (rdd[0]),
      .rd_valid     (rv[0]),
      .full         (fu[0]),
      .empty        (em[0]),
      .almost_full  (af[0]),
      .almost_empty (ae[0]),
      .count        (cnt8),
      .overflow     (ov[0]),
      .underflow    (un[0])
   );

   fifo_sync_param #(
      .DATA_WIDTH (8),
      .DEPTH      (5),
      .AF_THRESH  (3),
      .AE_THRESH  (2)
   ) dut5 (
      .CLK          (CLK),
      .RST          (rst[1]),
      .clear        (clr[1]),
      .wr_en        (we[1]),
      .wr_data      (wd[1]),
      .rd_en        (re[1]),
      .rd_data      (rdd[1]),
      .rd_valid     (rv[1]),
      .full         (fu[1]),
      .empty        (em[1]),
      .almost_full  (af[1]),
      .almost_empty (ae[1]),
      .count        (cnt5),
      .overflow     (ov[1]),
      .underflow    (un[1])
   );

   // Reference model state
   logic [7:0] mq [2][$];
   logic [7:0] m_rd [2];
   logic       m_rv [2];
   err_e       m_err [2];

   int ntest = 0;
   int nfail = 0;

   task automatic chk(input string tag, input int i, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   // Apply one clock edge's worth of FIFO rules to the queue model.
   task automatic model(input int i);
      int n;
      n = mq[i].size();
      if (rst[i]) begin
         mq[i].delete();
         m_rd[i]  = 8'h00;
         m_rv[i]  = 1'b0;
         m_err[i] = ERR_NONE;
      end else if (clr[i]) begin
         mq[i].delete();
         m_rv[i]  = 1'b0;
         m_err[i] = ERR_NONE;
      end else begin
         m_err[i] = ERR_NONE;
         if (we[i] && n == int'(dep[i]) && !re[i]) m_err[i] = ERR_OVF;
         if (re[i] && n == 0) m_err[i] = ERR_UDF;
         m_rv[i] = 1'b0;
         if (re[i] && n > 0) begin
            m_rd[i] = mq[i].pop_front();
            m_rv[i] = 1'b1;
         end
         if (we[i] && (n < int'(dep[i]) || re[i])) mq[i].push_back(wd[i]);
      end
   endtask

   task automatic check(input int i);
      int         n;
      logic [3:0] c;
      err_e       e;
      n = mq[i].size();
      c = (i == 0) ? cnt8 : {1'b0, cnt5};
      if (ov[i] && un[i])  e = err_e'(2'd3);
      else if (ov[i])      e = ERR_OVF;
      else if (un[i])      e = ERR_UDF;
      else                 e = ERR_NONE;
      chk("count", i, 32'(c), 32'(n));
      chk("empty", i, 32'(em[i]), 32'(n == 0));
      chk("full", i, 32'(fu[i]), 32'(n == int'(dep[i])));
      chk("almost_full", i, 32'(af[i]), 32'(n >= int'(afth[i])));
      chk("almost_empty", i, 32'(ae[i]), 32'(n <= int'(aeth[i])));
      chk("err", i, 32'(e), 32'(m_err[i]));
`ifdef FIFO_SYNC_FWFT_EN
      chk("rd_valid", i, 32'(rv[i]), 32'(n != 0));
      if (n != 0) chk("rd_data", i, 32'(rdd[i]), 32'(mq[i][0]));
`else
      chk("rd_valid", i, 32'(rv[i]), 32'(m_rv[i]));
      chk("rd_data", i, 32'(rdd[i]), 32'(m_rd[i]));
`endif
   endtask

   task automatic step();
      @(posedge CLK);
      for (int i = 0; i < 2; i++) model(i);
      #1;
      for (int i = 0; i < 2; i++) check(i);
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0;
         clr[i] = 1'b0;
         we[i]  = 1'b0;
         re[i]  = 1'b0;
         wd[i]  = 8'h00;
      end
   endtask

   initial begin
      dep[0] = 8;  afth[0] = 6;  aeth[0] = 2;
      dep[1] = 5;  afth[1] = 3;  aeth[1] = 2;
      idle_all();

      // Reset, then idle
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      step();
      step();
      idle_all();
      step();

      // Fill the DEPTH=8 instance with 0x01..0x08
      for (int k = 1; k <= 8; k++) begin
         we[0] = 1'b1;
         wd[0] = 8'(k);
         step();
      end
      // Write while full, no read: overflow
      wd[0] = 8'hAA;
      step();
      // Write and read while full
      wd[0] = 8'h55;
      re[0] = 1'b1;
      step();
      // Drain, then one more read on empty for underflow
      we[0] = 1'b0;
      for (int k = 0; k < 9; k++) step();
      idle_all();

      // DEPTH=5 steady-state streaming across pointer wrap
      for (int k = 0; k < 12; k++) begin
         we[1] = 1'b1;
         re[1] = 1'b1;
         wd[1] = 8'(k);
         step();
      end
      we[1] = 1'b0;
      step();
      idle_all();
      step();

      // Mid-stream flush with four entries
      for (int k = 0; k < 4; k++) begin
         we[0] = 1'b1;
         wd[0] = 8'(8'hC0 + k);
         step();
      end
      we[0]  = 1'b0;
      clr[0] = 1'b1;
      step();
      clr[0] = 1'b0;
      step();

      // Reset in the middle of a burst
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 2; i++) begin
            we[i] = 1'b1;
            re[i] = (k == 3);
            wd[i] = 8'($urandom);
         end
         step();
      end
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      step();
      idle_all();
      step();

      // Randomised traffic with shifting write/read bias
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 2; i++) begin
            int wb;
            int rb;
            wb = ((c / 100) % 2 == 0) ? 70 : 35;
            rb = ((c / 100) % 2 == 0) ? 35 : 70;
            rst[i] = ($urandom_range(0, 299) == 0);
            clr[i] = ($urandom_range(0, 79) == 0);
            we[i]  = ($urandom_range(0, 99) < wb);
            re[i]  = ($urandom_range(0, 99) < rb);
            wd[i]  = 8'($urandom);
         end
         step();
      end
      idle_all();
      step();

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
